dsram_confreg_resp: RTL and testbench



---
 rtl/dsram_confreg_resp.sv | 97 +++++++++
 tb/tb_dsram_confreg_resp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_confreg_resp.sv
// Data-SRAM responder: word RAM plus a config window (LED, switch, number, timer).
// Every request returns the pre-access word on rdata one edge later (read-first).
module dsram_confreg_resp #(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] CONF_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_SWITCH = 16'h0004;
  localparam logic [15:0] OFF_NUM    = 16'h0008;
  localparam logic [15:0] OFF_TIMER  = 16'h000c;

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  logic [15:0]       led_q;
  logic [31:0]       num_q;
  logic [31:0]       timer_q;
  logic [31:0]       rdata_q;
  logic              conf_sel;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       offset;
  logic [31:0]       mask;
  logic [31:0]       conf_rd;
  logic [31:0]       rd_word;
  logic [31:0]       merged;
  logic              wr_req;
  logic              unused_addr;

  assign conf_sel    = (data_sram_addr[31:16] == CONF_HI);
  assign idx         = data_sram_addr[ADDR_W+1:2];
  assign offset      = data_sram_addr[15:0];
  assign unused_addr = ^data_sram_addr[1:0];
  assign mask        = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                        {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
  assign wr_req      = resetn && data_sram_en && (data_sram_wen != 4'b0000);

  always_comb begin
    conf_rd = 32'h0;
    case (offset)
      OFF_LED:    conf_rd = {16'h0, led_q};
      OFF_SWITCH: conf_rd = {24'h0, switch};
      OFF_NUM:    conf_rd = num_q;
      OFF_TIMER:  conf_rd = timer_q;
      default:    conf_rd = 32'h0;
    endcase
  end

  // The old word feeds both the read-first response and the byte-lane merge.
  assign rd_word = conf_sel ? conf_rd : ram[idx];
  assign merged  = (data_sram_wdata & mask) | (rd_word & ~mask);

  // RAM contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clk) begin
    if (wr_req && !conf_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) ram[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= 32'h0;
      led_q   <= 16'h0;
      num_q   <= 32'h0;
      timer_q <= 32'h0;
    end else begin
      timer_q <= timer_q + 32'd1;
      if (data_sram_en) rdata_q <= rd_word;
      // A timer write loads the merged value instead of incrementing.
      if (wr_req && conf_sel) begin
        case (offset)
          OFF_LED:   led_q   <= merged[15:0];
          OFF_NUM:   num_q   <= merged;
          OFF_TIMER: timer_q <= merged;
          default:   ;
        endcase
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;

endmodule

// File: tb/tb_dsram_confreg_resp.sv
// Self-checking bench for dsram_confreg_resp: directed scenarios plus randomized
// traffic against a behavioural model of RAM and config registers.
module tb_dsram_confreg_resp;

  localparam logic [31:0] CONF = 32'hbfaf0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] mem_m [int];
  logic [31:0] rdata_m;
  logic [15:0] led_m;
  logic [31:0] num_m;
  logic [31:0] timer_m;

  dsram_confreg_resp dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch          (switch),
    .led             (led),
    .num_data        (num_data)
  );

  always #5 clk = ~clk;

  // Apply one request, advance one edge, update the model, settle before returning.
  task automatic do_cycle(input logic en, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask, old, nxt_timer;
    int key;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = wen[i] ? 8'hff : 8'h00;
    if (!resetn) begin
      rdata_m = 0; led_m = 0; num_m = 0; timer_m = 0;
    end else begin
      nxt_timer = timer_m + 1;
      if (en) begin
        if (addr[31:16] == 16'hbfaf) begin
          case (addr[15:0])
            16'h0000: old = {16'h0, led_m};
            16'h0004: old = {24'h0, switch};
            16'h0008: old = num_m;
            16'h000c: old = timer_m;
            default:  old = 0;
          endcase
          rdata_m = old;
          if (wen != 0) begin
            case (addr[15:0])
              16'h0000: led_m = 16'((wdata & mask) | (old & ~mask));
              16'h0008: num_m = (wdata & mask) | (old & ~mask);
              16'h000c: nxt_timer = (wdata & mask) | (old & ~mask);
              default: ;
            endcase
          end
        end else begin
          key = int'(addr[15:2]);
          old = mem_m.exists(key) ? mem_m[key] : 32'h0;
          rdata_m = old;
          if (wen != 0) mem_m[key] = (wdata & mask) | (old & ~mask);
        end
      end
      timer_m = nxt_timer;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    idle(2);
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", data_sram_rdata, 32'h0); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0); end
    checks++; if (num_data !== 32'h0) begin errors++; $display("FAIL reset_num got=%h exp=%h", num_data, 32'h0); end
  endtask

  task automatic test_timer;
    resetn = 1'b1;
    idle(5);
    do_cycle(1'b1, 4'h0, CONF | 32'hc, 32'h0);
    checks++; if (data_sram_rdata !== 32'd5) begin errors++; $display("FAIL timer_after_release got=%h exp=%h", data_sram_rdata, 32'd5); end
    do_cycle(1'b1, 4'hf, CONF | 32'hc, 32'hfffffffe);
    idle(1);
    do_cycle(1'b1, 4'h0, CONF | 32'hc, 32'h0);
    checks++; if (data_sram_rdata !== 32'hffffffff) begin errors++; $display("FAIL timer_pre_wrap got=%h exp=%h", data_sram_rdata, 32'hffffffff); end
    do_cycle(1'b1, 4'h0, CONF | 32'hc, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL timer_wrap got=%h exp=%h", data_sram_rdata, 32'h0); end
  endtask

  task automatic test_ram_word;
    do_cycle(1'b1, 4'hf, 32'h00001000, 32'h12345678);
    do_cycle(1'b1, 4'h0, 32'h00001000, 32'h0);
    checks++; if (data_sram_rdata !== 32'h12345678) begin errors++; $display("FAIL ram_word got=%h exp=%h", data_sram_rdata, 32'h12345678); end
  endtask

  task automatic test_byte_lanes;
    do_cycle(1'b1, 4'hf, 32'h00001004, 32'haabbccdd);
    do_cycle(1'b1, 4'b0101, 32'h00001004, 32'h11223344);
    checks++; if (data_sram_rdata !== 32'haabbccdd) begin errors++; $display("FAIL lane_read_first got=%h exp=%h", data_sram_rdata, 32'haabbccdd); end
    do_cycle(1'b1, 4'h0, 32'h00001004, 32'h0);
    checks++; if (data_sram_rdata !== 32'haa22cc44) begin errors++; $display("FAIL lane_merge got=%h exp=%h", data_sram_rdata, 32'haa22cc44); end
  endtask

  task automatic test_config;
    switch = 8'h5a;
    do_cycle(1'b1, 4'hf, CONF | 32'h0, 32'hffff1234);
    checks++; if (led !== 16'h1234) begin errors++; $display("FAIL led_out got=%h exp=%h", led, 16'h1234); end
    do_cycle(1'b1, 4'h0, CONF | 32'h0, 32'h0);
    checks++; if (data_sram_rdata !== 32'h00001234) begin errors++; $display("FAIL led_read got=%h exp=%h", data_sram_rdata, 32'h00001234); end
    do_cycle(1'b1, 4'h0, CONF | 32'h4, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0000005a) begin errors++; $display("FAIL switch_read got=%h exp=%h", data_sram_rdata, 32'h0000005a); end
    do_cycle(1'b1, 4'hf, CONF | 32'h4, 32'h000000ff);
    do_cycle(1'b1, 4'h0, CONF | 32'h4, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0000005a) begin errors++; $display("FAIL switch_write_ignored got=%h exp=%h", data_sram_rdata, 32'h0000005a); end
    do_cycle(1'b1, 4'hf, CONF | 32'h8, 32'hdeadbeef);
    do_cycle(1'b1, 4'b0011, CONF | 32'h20, 32'h0bad0bad);
    do_cycle(1'b1, 4'h0, CONF | 32'h20, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=%h", data_sram_rdata, 32'h0); end
    checks++; if (num_data !== 32'hdeadbeef) begin errors++; $display("FAIL num_out got=%h exp=%h", num_data, 32'hdeadbeef); end
    checks++; if (led !== 16'h1234) begin errors++; $display("FAIL led_kept got=%h exp=%h", led, 16'h1234); end
  endtask

  task automatic test_hold_reset;
    logic [31:0] held;
    do_cycle(1'b1, 4'h0, 32'h00001000, 32'h0);
    held = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 4'hf, 32'h00001000, 32'hffffffff);
      checks++; if (data_sram_rdata !== held) begin errors++; $display("FAIL idle_hold%0d got=%h exp=%h", i, data_sram_rdata, held); end
    end
    resetn = 1'b0;
    idle(1);
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL hold_reset_rdata got=%h exp=%h", data_sram_rdata, 32'h0); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL hold_reset_led got=%h exp=%h", led, 16'h0); end
    resetn = 1'b1;
  endtask

  task automatic test_reset_midstream;
    do_cycle(1'b1, 4'hf, 32'h00002000, 32'hcafef00d);
    resetn = 1'b0;
    do_cycle(1'b1, 4'hf, 32'h00002000, 32'h5555aaaa);
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL midreset_rdata got=%h exp=%h", data_sram_rdata, 32'h0); end
    resetn = 1'b1;
    do_cycle(1'b1, 4'h0, CONF | 32'hc, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL midreset_timer got=%h exp=%h", data_sram_rdata, 32'h0); end
    do_cycle(1'b1, 4'h0, 32'h00002000, 32'h0);
    checks++; if (data_sram_rdata !== 32'hcafef00d) begin errors++; $display("FAIL midreset_ram got=%h exp=%h", data_sram_rdata, 32'hcafef00d); end
  endtask

  task automatic test_random;
    logic [31:0] addr;
    logic [15:0] hi;
    logic [3:0]  wen;
    logic [15:0] offs [5];
    offs[0] = 16'h0; offs[1] = 16'h4; offs[2] = 16'h8; offs[3] = 16'hc; offs[4] = 16'h20;
    // Preload every RAM word the traffic may read.
    for (int k = 0; k < 8; k++) do_cycle(1'b1, 4'hf, 32'h00003000 + 32'(k * 4), $urandom);
    for (int n = 0; n < 400; n++) begin
      switch = 8'($urandom);
      wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        addr = CONF | {16'h0, offs[$urandom_range(0, 4)]};
      end else begin
        hi = 16'($urandom);
        if (hi == 16'hbfaf) hi = 16'h0;
        addr = {hi, 16'h3000 + 16'($urandom_range(0, 7) * 4)} | 32'($urandom_range(0, 3));
      end
      do_cycle($urandom_range(0, 3) != 0, wen, addr, $urandom);
      checks++; if (data_sram_rdata !== rdata_m) begin errors++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, data_sram_rdata, rdata_m); end
      checks++; if (led !== led_m) begin errors++; $display("FAIL rand_led n=%0d got=%h exp=%h", n, led, led_m); end
      checks++; if (num_data !== num_m) begin errors++; $display("FAIL rand_num n=%0d got=%h exp=%h", n, num_data, num_m); end
    end
    do_cycle(1'b1, 4'h0, CONF | 32'hc, 32'h0);
    checks++; if (data_sram_rdata !== rdata_m) begin errors++; $display("FAIL rand_timer got=%h exp=%h", data_sram_rdata, rdata_m); end
  endtask

  initial begin
    resetn = 1'b0;
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    switch = 8'h0;
    rdata_m = 0; led_m = 0; num_m = 0; timer_m = 0;
    test_reset();
    test_timer();
    test_ram_word();
    test_byte_lanes();
    test_config();
    test_hold_reset();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
